// File: rtl/myproject_mul_pipe_sxu.sv
// myproject_mul_pipe_sxu: pipelined signed x unsigned multiplier with round/saturate and per-stage backpressure
module myproject_mul_pipe_sxu #(
  parameter int DIN0_WIDTH = 18,
  parameter int DIN1_WIDTH = 17,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_sat,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int P  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int PW = P + 1;
  localparam logic signed [P:0] RND = (ROUND != 0 && SHIFT > 0) ? (PW'(1) << SHIFT) >> 1 : '0;
  localparam logic signed [P:0] HI  = (PW'(1) << (DOUT_WIDTH - 1)) - PW'(1);
  localparam logic signed [P:0] LO  = -(PW'(1) << (DOUT_WIDTH - 1));
  logic [NUM_STAGE-1:0]  v, vin, adv;
  logic signed [P-1:0]   prod, tail;
  logic signed [P:0]     r;
  logic                  ovf;
  logic [DOUT_WIDTH-1:0] res;
  assign prod      = P'($signed(din0)) * P'($signed({1'b0, din1}));
  assign vin       = NUM_STAGE'({v, in_valid});
  assign in_ready  = adv[0];
  assign out_valid = v[NUM_STAGE-1];
  always_comb
    for (int k = 0; k < NUM_STAGE; k++)
      adv[k] = out_ready | ~&(v | ((NUM_STAGE'(1) << k) - NUM_STAGE'(1)));
  always_comb begin
    r   = $signed({tail[P-1], tail} + RND) >>> SHIFT;
    ovf = r > HI || r < LO;
    res = (ovf && SAT != 0) ? (r[P] ? LO[DOUT_WIDTH-1:0] : HI[DOUT_WIDTH-1:0]) : r[DOUT_WIDTH-1:0];
  end
  if (NUM_STAGE == 1) begin : g_one
    assign tail = prod;
  end else begin : g_pipe
    logic signed [P-1:0] pipe [NUM_STAGE-1];
    always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n)
        for (int k = 0; k < NUM_STAGE - 1; k++) pipe[k] <= '0;
      else
        for (int k = 0; k < NUM_STAGE - 1; k++)
          if (adv[k] && vin[k]) pipe[k] <= (k == 0) ? prod : pipe[(k == 0) ? 0 : k - 1];
    assign tail = pipe[NUM_STAGE-2];
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      v        <= '0;
      dout     <= '0;
      dout_sat <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGE; k++) if (adv[k]) v[k] <= vin[k];
      if (adv[NUM_STAGE-1] && vin[NUM_STAGE-1]) begin
        dout     <= res;
        dout_sat <= ovf;
      end
    end
endmodule
